// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared types and constants for the PS/2 Set-2 scan-code decoder (package ps2_pkg).
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GOT_E0,
    GOT_F0,
    GOT_E0_F0,
    SKIP_E1
  } ps2_state_t;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
    logic [7:0] ascii;
  } key_event_t;

  // Keyboard status/acknowledge bytes that never belong to a key sequence.
  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA,
      8'hFC, 8'hFD, 8'hFE, 8'hFF: is_discard = 1'b1;
      default:                    is_discard = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Set-2 base code to ASCII translation, purely combinational.
// Latency: none. Backpressure: none (no state).
// Letters follow shift ^ caps; other printables follow shift; ext keys map only keypad / and Enter.
module ps2_ascii_lut
  import ps2_pkg::*;
(
  input  logic       shift,
  input  logic       caps,
  input  logic       ext,
  input  logic [7:0] code,
  output logic [7:0] ascii
);

  logic [7:0] lower;
  logic [7:0] upper;
  logic       letter;

  always_comb begin
    lower  = 8'h00;
    upper  = 8'h00;
    letter = 1'b0;
    ascii  = 8'h00;
    case (code)
      8'h1C: begin lower = "a"; letter = 1'b1; end
      8'h32: begin lower = "b"; letter = 1'b1; end
      8'h21: begin lower = "c"; letter = 1'b1; end
      8'h23: begin lower = "d"; letter = 1'b1; end
      8'h24: begin lower = "e"; letter = 1'b1; end
      8'h2B: begin lower = "f"; letter = 1'b1; end
      8'h34: begin lower = "g"; letter = 1'b1; end
      8'h33: begin lower = "h"; letter = 1'b1; end
      8'h43: begin lower = "i"; letter = 1'b1; end
      8'h3B: begin lower = "j"; letter = 1'b1; end
      8'h42: begin lower = "k"; letter = 1'b1; end
      8'h4B: begin lower = "l"; letter = 1'b1; end
      8'h3A: begin lower = "m"; letter = 1'b1; end
      8'h31: begin lower = "n"; letter = 1'b1; end
      8'h44: begin lower = "o"; letter = 1'b1; end
      8'h4D: begin lower = "p"; letter = 1'b1; end
      8'h15: begin lower = "q"; letter = 1'b1; end
      8'h2D: begin lower = "r"; letter = 1'b1; end
      8'h1B: begin lower = "s"; letter = 1'b1; end
      8'h2C: begin lower = "t"; letter = 1'b1; end
      8'h3C: begin lower = "u"; letter = 1'b1; end
      8'h2A: begin lower = "v"; letter = 1'b1; end
      8'h1D: begin lower = "w"; letter = 1'b1; end
      8'h22: begin lower = "x"; letter = 1'b1; end
      8'h35: begin lower = "y"; letter = 1'b1; end
      8'h1A: begin lower = "z"; letter = 1'b1; end
      8'h16: begin lower = "1"; upper = "!"; end
      8'h1E: begin lower = "2"; upper = "@"; end
      8'h26: begin lower = "3"; upper = "#"; end
      8'h25: begin lower = "4"; upper = "$"; end
      8'h2E: begin lower = "5"; upper = "%"; end
      8'h36: begin lower = "6"; upper = "^"; end
      8'h3D: begin lower = "7"; upper = "&"; end
      8'h3E: begin lower = "8"; upper = "*"; end
      8'h46: begin lower = "9"; upper = "("; end
      8'h45: begin lower = "0"; upper = ")"; end
      8'h4E: begin lower = "-"; upper = "_"; end
      8'h55: begin lower = "="; upper = "+"; end
      8'h54: begin lower = "["; upper = "{"; end
      8'h5B: begin lower = "]"; upper = "}"; end
      8'h5D: begin lower = "\\"; upper = "|"; end
      8'h4C: begin lower = ";"; upper = ":"; end
      8'h52: begin lower = "'"; upper = "\""; end
      8'h0E: begin lower = 8'h60; upper = "~"; end
      8'h41: begin lower = ","; upper = "<"; end
      8'h49: begin lower = "."; upper = ">"; end
      8'h4A: begin lower = "/"; upper = "?"; end
      8'h29: begin lower = " "; upper = " "; end
      8'h5A: begin lower = 8'h0D; upper = 8'h0D; end
      8'h66: begin lower = 8'h08; upper = 8'h08; end
      8'h0D: begin lower = 8'h09; upper = 8'h09; end
      8'h76: begin lower = 8'h1B; upper = 8'h1B; end
      default: ;
    endcase

    if (ext) begin
      if (code == 8'h4A)      ascii = 8'h2F;
      else if (code == 8'h5A) ascii = 8'h0D;
      else                    ascii = 8'h00;
    end else if (letter) begin
      ascii = (shift ^ caps) ? (lower - 8'h20) : lower;
    end else begin
      ascii = shift ? upper : lower;
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Assembles PS/2 Set-2 bytes into key events with modifiers and ASCII; optional CAPS_LOCK_EN adds caps_lock.
// Latency: event enqueued on the strobe edge, key_valid the following cycle (FWFT, registered head).
// Backpressure: key_valid/key_ready; when the FIFO is full and not popping, events drop and overflow sticks.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int E1_SKIP    = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_code_new,
  input  logic [7:0] ps2_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic [7:0] key_ascii,
  output logic       shift,
  output logic       ctrl,
  output logic       alt,
`ifdef CAPS_LOCK_EN
  output logic       caps_lock,
`endif
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(E1_SKIP + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  ps2_state_t     state, state_n;
  logic [SW-1:0]  skip_cnt, skip_n;
  logic           emit, ev_ext, ev_brk, fake_shift;
  logic [7:0]     ev_code, ev_ascii;
  key_event_t     ev;

  logic lshift, rshift, lctrl, rctrl, lalt, ralt;
  logic lshift_n, rshift_n, lctrl_n, rctrl_n, lalt_n, ralt_n;
  logic caps_q, caps_n;

  key_event_t     mem [FIFO_DEPTH];
  key_event_t     head_q, head_n;
  logic [AW-1:0]  rd_ptr, wr_ptr, rd_nxt;
  logic [CW-1:0]  count, count_n;
  logic           push, pop;

  assign fake_shift = (ps2_code == SC_LSHIFT) || (ps2_code == SC_RSHIFT);

  always_comb begin
    state_n = state;
    skip_n  = skip_cnt;
    emit    = 1'b0;
    ev_ext  = 1'b0;
    ev_brk  = 1'b0;
    ev_code = ps2_code;
    if (ps2_code_new) begin
      if (state == SKIP_E1) begin
        if (skip_cnt == SW'(1)) begin
          emit    = 1'b1;
          ev_code = SC_PAUSE;
          skip_n  = '0;
          state_n = IDLE;
        end else begin
          skip_n = skip_cnt - SW'(1);
        end
      end else if (is_discard(ps2_code)) begin
        state_n = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (ps2_code == SC_EXT)        state_n = GOT_E0;
            else if (ps2_code == SC_BREAK) state_n = GOT_F0;
            else if (ps2_code == SC_PAUSE) begin
              state_n = SKIP_E1;
              skip_n  = SW'(E1_SKIP);
            end else emit = 1'b1;
          end
          GOT_E0: begin
            if (ps2_code == SC_BREAK)    state_n = GOT_E0_F0;
            else if (ps2_code == SC_EXT) state_n = GOT_E0;
            else begin
              state_n = IDLE;
              emit    = !fake_shift;
              ev_ext  = 1'b1;
            end
          end
          GOT_F0: begin
            if (ps2_code == SC_EXT) state_n = GOT_E0;
            else begin
              state_n = IDLE;
              emit    = 1'b1;
              ev_brk  = 1'b1;
            end
          end
          GOT_E0_F0: begin
            state_n = IDLE;
            emit    = !fake_shift;
            ev_ext  = 1'b1;
            ev_brk  = 1'b1;
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // Modifier registers update with the event, so the event's ASCII sees the new shift state.
  always_comb begin
    lshift_n = lshift;
    rshift_n = rshift;
    lctrl_n  = lctrl;
    rctrl_n  = rctrl;
    lalt_n   = lalt;
    ralt_n   = ralt;
    caps_n   = caps_q;
    if (emit) begin
      case (ev_code)
        SC_LSHIFT: if (!ev_ext) lshift_n = !ev_brk;
        SC_RSHIFT: if (!ev_ext) rshift_n = !ev_brk;
        SC_CTRL:   if (ev_ext) rctrl_n = !ev_brk; else lctrl_n = !ev_brk;
        SC_ALT:    if (ev_ext) ralt_n  = !ev_brk; else lalt_n  = !ev_brk;
`ifdef CAPS_LOCK_EN
        SC_CAPS:   if (!ev_ext && !ev_brk) caps_n = !caps_q;
`endif
        default: ;
      endcase
    end
  end

  ps2_ascii_lut u_lut (
    .shift (lshift_n | rshift_n),
    .caps  (caps_q),
    .ext   (ev_ext),
    .code  (ev_code),
    .ascii (ev_ascii)
  );

  assign ev = '{ext: ev_ext, brk: ev_brk, code: ev_code, ascii: ev_ascii};

  assign pop     = key_valid & key_ready;
  assign push    = emit & ((count != FULL_CNT) | pop);
  assign count_n = count + CW'(push) - CW'(pop);
  assign rd_nxt  = rd_ptr + 1'b1;

  // The next head is the incoming event whenever the FIFO drains to exactly that event.
  always_comb begin
    head_n = head_q;
    if (count_n == '0)
      head_n = '0;
    else if (push && ((count == '0) || (pop && count == CW'(1))))
      head_n = ev;
    else if (pop)
      head_n = mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ev;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      skip_cnt <= '0;
      lshift   <= 1'b0;
      rshift   <= 1'b0;
      lctrl    <= 1'b0;
      rctrl    <= 1'b0;
      lalt     <= 1'b0;
      ralt     <= 1'b0;
      caps_q   <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      head_q   <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      skip_cnt <= skip_n;
      lshift   <= lshift_n;
      rshift   <= rshift_n;
      lctrl    <= lctrl_n;
      rctrl    <= rctrl_n;
      lalt     <= lalt_n;
      ralt     <= ralt_n;
      caps_q   <= caps_n;
      count    <= count_n;
      head_q   <= head_n;
      if (push)         wr_ptr   <= wr_ptr + 1'b1;
      if (pop)          rd_ptr   <= rd_nxt;
      if (emit && !push) overflow <= 1'b1;
    end
  end

  assign key_valid = (count != '0);
  assign key_code  = head_q.code;
  assign key_ext   = head_q.ext;
  assign key_break = head_q.brk;
  assign key_ascii = head_q.ascii;
  assign shift     = lshift | rshift;
  assign ctrl      = lctrl | rctrl;
  assign alt       = lalt | ralt;
`ifdef CAPS_LOCK_EN
  assign caps_lock = caps_q;
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder (default build, CAPS_LOCK_EN undefined).
module tb_ps2_scancode_decoder;
  import ps2_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_code_new = 1'b0;
  logic [7:0] ps2_code = 8'h00;
  logic       key_valid, key_ready;
  logic [7:0] key_code, key_ascii;
  logic       key_ext, key_break, shift, ctrl, alt, overflow;

  int n_cmp = 0;
  int n_err = 0;
  key_event_t exp_q[$];

  ps2_scancode_decoder #(.FIFO_DEPTH(8), .E1_SKIP(7)) dut (
    .clk(clk), .reset(reset), .ps2_code_new(ps2_code_new), .ps2_code(ps2_code),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
    .key_ext(key_ext), .key_break(key_break), .key_ascii(key_ascii),
    .shift(shift), .ctrl(ctrl), .alt(alt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b);
    ps2_code_new = 1'b1;
    ps2_code     = b;
    @(negedge clk);
    ps2_code_new = 1'b0;
    ps2_code     = 8'h00;
  endtask

  task automatic ev(input logic e, input logic b, input logic [7:0] c, input logic [7:0] a);
    exp_q.push_back({e, b, c, a});
  endtask

  task automatic test_reset;
    reset = 1'b1;
    key_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({key_valid, key_ext, key_break, key_code, key_ascii} !== 19'h0) begin
      n_err++; $display("FAIL reset_head: got %h want 0", {key_valid, key_ext, key_break, key_code, key_ascii});
    end
    n_cmp++;
    if ({shift, ctrl, alt, overflow} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got %b want 0000", {shift, ctrl, alt, overflow});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int n;
    key_event_t o, e;
    n_cmp++;
    if (key_valid !== 1'b0) begin n_err++; $display("FAIL basic_idle_valid: got %b want 0", key_valid); end
    ev(0, 0, 8'h1C, 8'h61);
    send_byte(8'h1C);
    n_cmp++;
    if (key_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency: valid %b want 1", key_valid); end
    key_ready = 1'b1; n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      if (key_valid) begin
        e = exp_q.pop_front(); o = {key_ext, key_break, key_code, key_ascii}; n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL basic_event: got %h want %h", o, e); end
      end
      @(negedge clk); n++;
    end
    key_ready = 1'b0; n_cmp++;
    if (exp_q.size() != 0 || key_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_drain: left %0d valid %b want 0 0", exp_q.size(), key_valid); exp_q.delete();
    end
  endtask

  task automatic test_shift;
    int n;
    key_event_t o, e;
    ev(0, 0, 8'h12, 8'h00); ev(0, 0, 8'h1C, 8'h41);
    ev(0, 1, 8'h1C, 8'h41); ev(0, 1, 8'h12, 8'h00);
    send_byte(8'h12);
    n_cmp++;
    if (shift !== 1'b1) begin n_err++; $display("FAIL shift_held: got %b want 1", shift); end
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h12);
    n_cmp++;
    if (shift !== 1'b0) begin n_err++; $display("FAIL shift_released: got %b want 0", shift); end
    key_ready = 1'b1; n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      if (key_valid) begin
        e = exp_q.pop_front(); o = {key_ext, key_break, key_code, key_ascii}; n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL shift_event: got %h want %h", o, e); end
      end
      @(negedge clk); n++;
    end
    key_ready = 1'b0; n_cmp++;
    if (exp_q.size() != 0 || key_valid !== 1'b0) begin
      n_err++; $display("FAIL shift_drain: left %0d valid %b want 0 0", exp_q.size(), key_valid); exp_q.delete();
    end
  endtask

  task automatic test_ext;
    int n;
    key_event_t o, e;
    logic [7:0] seq [18] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h4A, 8'hE0, 8'h5A,
                             8'hE0, 8'h12, 8'hE0, 8'hF0, 8'h12, 8'h14, 8'hE0, 8'h14, 8'hF0};
    ev(1, 0, 8'h75, 8'h00); ev(1, 1, 8'h75, 8'h00); ev(1, 0, 8'h4A, 8'h2F); ev(1, 0, 8'h5A, 8'h0D);
    ev(0, 0, 8'h14, 8'h00); ev(1, 0, 8'h14, 8'h00); ev(0, 1, 8'h14, 8'h00); ev(1, 1, 8'h14, 8'h00);
    for (int i = 0; i < 18; i++) send_byte(seq[i]);
    send_byte(8'h14);
    n_cmp++;
    if ({shift, ctrl} !== 2'b01) begin n_err++; $display("FAIL ext_fake_shift_ctrl: got %b want 01", {shift, ctrl}); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
    n_cmp++;
    if ({ctrl, overflow} !== 2'b00) begin n_err++; $display("FAIL ext_ctrl_full: got %b want 00", {ctrl, overflow}); end
    key_ready = 1'b1; n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      if (key_valid) begin
        e = exp_q.pop_front(); o = {key_ext, key_break, key_code, key_ascii}; n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL ext_event: got %h want %h", o, e); end
      end
      @(negedge clk); n++;
    end
    key_ready = 1'b0; n_cmp++;
    if (exp_q.size() != 0 || key_valid !== 1'b0) begin
      n_err++; $display("FAIL ext_drain: left %0d valid %b want 0 0", exp_q.size(), key_valid); exp_q.delete();
    end
  endtask

  task automatic test_pause;
    int n;
    key_event_t o, e;
    logic [7:0] seq [7] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0};
    ev(0, 0, 8'hE1, 8'h00); ev(0, 0, 8'h1C, 8'h61);
    for (int i = 0; i < 7; i++) send_byte(seq[i]);
    n_cmp++;
    if (key_valid !== 1'b0) begin n_err++; $display("FAIL pause_early: valid %b want 0", key_valid); end
    send_byte(8'h77);
    n_cmp++;
    if ({key_valid, ctrl} !== 2'b10) begin n_err++; $display("FAIL pause_done: valid,ctrl %b want 10", {key_valid, ctrl}); end
    send_byte(8'h1C);
    key_ready = 1'b1; n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      if (key_valid) begin
        e = exp_q.pop_front(); o = {key_ext, key_break, key_code, key_ascii}; n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL pause_event: got %h want %h", o, e); end
      end
      @(negedge clk); n++;
    end
    key_ready = 1'b0; n_cmp++;
    if (exp_q.size() != 0 || key_valid !== 1'b0) begin
      n_err++; $display("FAIL pause_drain: left %0d valid %b want 0 0", exp_q.size(), key_valid); exp_q.delete();
    end
  endtask

  task automatic test_overflow;
    int n;
    key_event_t o, e;
    logic [7:0] codes [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    logic [7:0] chars [9] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};
    for (int i = 0; i < 9; i++) begin
      if (i < 8) ev(0, 0, codes[i], chars[i]);
      if (i == 8) begin
        n_cmp++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_at_full: got %b want 0", overflow); end
      end
      send_byte(codes[i]);
      n_cmp++;
      if ({key_valid, key_code, key_ascii} !== {1'b1, 8'h1C, 8'h61}) begin
        n_err++; $display("FAIL ovf_head_stable: got %h want 11c61", {key_valid, key_code, key_ascii});
      end
    end
    n_cmp++;
    if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    key_ready = 1'b1; n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      if (key_valid) begin
        e = exp_q.pop_front(); o = {key_ext, key_break, key_code, key_ascii}; n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL ovf_event: got %h want %h", o, e); end
      end
      @(negedge clk); n++;
    end
    key_ready = 1'b0; n_cmp++;
    if (exp_q.size() != 0 || key_valid !== 1'b0 || overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_drain: left %0d valid %b ovf %b want 0 0 1", exp_q.size(), key_valid, overflow);
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid;
    int n;
    key_event_t o, e;
    logic [7:0] seq [13] = '{8'h32, 8'hAA, 8'hFA, 8'h21, 8'hE0, 8'hAA, 8'h1C,
                             8'hF0, 8'hFA, 8'h23, 8'h11, 8'hF0, 8'h11};
    send_byte(8'hE0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({key_valid, overflow} !== 2'b00) begin n_err++; $display("FAIL rst_mid_clear: got %b want 00", {key_valid, overflow}); end
    ev(0, 0, 8'h1C, 8'h61); ev(0, 0, 8'h32, 8'h62); ev(0, 0, 8'h21, 8'h63); ev(0, 0, 8'h1C, 8'h61);
    ev(0, 0, 8'h23, 8'h64); ev(0, 0, 8'h11, 8'h00); ev(0, 1, 8'h11, 8'h00);
    send_byte(8'h1C);
    for (int i = 0; i < 11; i++) send_byte(seq[i]);
    n_cmp++;
    if (alt !== 1'b1) begin n_err++; $display("FAIL alt_held: got %b want 1", alt); end
    send_byte(seq[11]); send_byte(seq[12]);
    n_cmp++;
    if (alt !== 1'b0) begin n_err++; $display("FAIL alt_released: got %b want 0", alt); end
    key_ready = 1'b1; n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      if (key_valid) begin
        e = exp_q.pop_front(); o = {key_ext, key_break, key_code, key_ascii}; n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL rst_mid_event: got %h want %h", o, e); end
      end
      @(negedge clk); n++;
    end
    key_ready = 1'b0; n_cmp++;
    if (exp_q.size() != 0 || key_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_drain: left %0d valid %b want 0 0", exp_q.size(), key_valid); exp_q.delete();
    end
  endtask

  initial begin
    key_ready = 1'b0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_shift;
    test_ext;
    test_pause;
    test_overflow;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
